frame_crc_monitor: RTL and testbench
====================================

# frame_crc_monitor

Pixel-stream consumer on the NES video output: tracks raster position from `pixel`/`pixel_en`, writes each pixel into an external frame buffer, and computes a CRC-32 per frame, closing the frame at the rising edge of `vblank`. Sits directly downstream of `nes` in the simulation bench and the FPGA top, alongside the video path. Gives regression tests a per-frame signature and catches short or long frames.

## Interface
- `WIDTH`, 256: active pixels per line.
- `HEIGHT`, 240: active lines per frame.
- `AW`, 16: frame-buffer address width. Must satisfy 2^AW >= WIDTH*HEIGHT.
- `clk`  in  1: pixel clock; `pixel`, `pixel_en` and `vblank` are synchronous to it.
- `rst`  in  1: synchronous, active-high reset.
- `pixel`  in  8: palette-index pixel from `nes`.
- `pixel_en`  in  1: `pixel` is valid this cycle.
- `vblank`  in  1: level, high during vertical blank.
- `fb_we`  out  1: frame-buffer write strobe.
- `fb_addr`  out  AW: write address, y*WIDTH + x.
- `fb_data`  out  8: write data.
- `frame_done`  out  1: single-cycle pulse when a frame closes.
- `frame_crc`  out  32: CRC of the last closed frame. Held until the next close.
- `frame_ok`  out  1: the last closed frame had exactly WIDTH*HEIGHT pixels.
- `frame_num`  out  16: count of closed frames. Wraps from 0xFFFF to 0.
- `err_overrun`  out  1: sticky. A pixel arrived after the frame was already full.
- `err_underrun`  out  1: sticky. A frame closed with fewer than WIDTH*HEIGHT pixels.

## Operation
- The design is fixed: one clock, synchronous active-high reset.
- **States**
  - SYNC: entered from reset. Pixels are ignored, with no writes and no CRC update.
  - ACTIVE: entered on the first `vblank` rise seen in SYNC. That rise does not pulse `frame_done`.
  - There is no other transition. Reset from any state returns to SYNC.
- **vblank edge:** `vblank_q` is a registered copy of `vblank`. A rise is `vblank & ~vblank_q`. `vblank_q` resets to 1, so a `vblank` that is high out of reset does not count as a rise.
- **Accepting pixels in ACTIVE:** each `pixel_en` cycle with `cnt < WIDTH*HEIGHT` is accepted and does three things:
  - writes `pixel` to `{y*WIDTH+x}`;
  - folds `pixel` into the running CRC;
  - increments `cnt`, x and y. x wraps WIDTH-1→0 and increments y.
- **Overrun:** `pixel_en` with `cnt == WIDTH*HEIGHT` sets `err_overrun`. The pixel is dropped: no write, no CRC update, and `cnt` saturates.
- **CRC:** CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF. Processed one byte per accepted pixel, LSB first.
- **Frame close** (`vblank` rise in ACTIVE):
  - `frame_crc` <= final CRC;
  - `frame_ok` <= (`cnt` == WIDTH*HEIGHT);
  - `frame_num` += 1;
  - `err_underrun` is set if `cnt` < WIDTH*HEIGHT;
  - the running CRC, `cnt`, x and y reinitialise.
- **Pixel on the close cycle:** if `pixel_en` coincides with the `vblank` rise, that pixel is accepted and included in the closing frame's CRC and count before the close. The next frame then starts from a clean state.
- **pixel_en during vblank** is accepted like any other pixel. The count check at close catches any mismatch.
- **Reset values:** all outputs 0, except `frame_crc` = 0x00000000.

## Timing
- Frame-buffer write latency is 1 cycle: `fb_we`/`fb_addr`/`fb_data` are registered and valid in the cycle after the `pixel_en` sample. `fb_we` is high for exactly 1 cycle per accepted pixel.
- `frame_done` is high for the one cycle after the edge where `vblank` is first sampled high. `frame_crc`, `frame_ok` and `frame_num` are updated on that same edge, so they are stable while `frame_done` is high.
- Back-to-back `pixel_en` on every cycle is supported with no stall. There is no backpressure; the frame buffer must accept one write per cycle.
- Reset mid-frame: the next cycle is SYNC with all outputs at their reset values. No partial frame is reported.

## Structure
- Put the CRC-32 constants (polynomial, initial value, final XOR) and a `crc32_byte` function in shared package `nes_dbg_pkg`. This lets the bench model reuse them.
- Make one sub-module, `crc32_byte_update`: combinational 8-bit CRC step, in: crc[31:0] and data[7:0], out: next crc.
- The state machine, raster counters, edge detect and sticky errors all live in `frame_crc_monitor`.

## Test plan
- WIDTH=9, HEIGHT=1. Raise `vblank` once, feed bytes 0x31..0x39 with `pixel_en`, then raise `vblank` again → `frame_done` pulses once, `frame_crc`=0xCBF43926, `frame_ok`=1, `frame_num`=1.
- Defaults, feed a full 61440-pixel frame with `pixel`=x[7:0] → 61440 `fb_we` pulses, last `fb_addr`=0xEFFF with `fb_data`=0xFF, and `frame_crc` matches the package-function model.
- WIDTH=9, HEIGHT=1, 10 pixels in a frame → `err_overrun`=1, 9 writes only, `frame_ok`=1 at close, CRC unchanged by the 10th byte.
- WIDTH=9, HEIGHT=1, 8 pixels in a frame → at close `frame_ok`=0, `err_underrun`=1, `frame_num` still increments.
- Last pixel coincides with the `vblank` rise → pixel included in the closing CRC (0xCBF43926 case), and the next frame starts with `fb_addr`=0.
- Pixels before the first `vblank`, plus reset asserted mid-frame → no `fb_we` while in SYNC, no `frame_done` on the first rise, counters back to 0.

Source files
------------

// File: rtl/nes_dbg_pkg.sv
// rtl/nes_dbg_pkg.sv - CRC-32 constants, monitor state type and byte-step helper
package nes_dbg_pkg;

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } mon_state_e;

    // Reflected CRC-32 step: one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// rtl/crc32_byte_update.sv - combinational single-byte CRC-32 update
module crc32_byte_update
    import nes_dbg_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_byte(crc, data);

endmodule

// File: rtl/frame_crc_monitor.sv
// rtl/frame_crc_monitor.sv - raster tracking, frame-buffer writes and per-frame CRC-32
module frame_crc_monitor
    import nes_dbg_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 240,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    pixel,
    input  logic          pixel_en,
    input  logic          vblank,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic          frame_done,
    output logic [31:0]   frame_crc,
    output logic          frame_ok,
    output logic [15:0]   frame_num,
    output logic          err_overrun,
    output logic          err_underrun
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW    = $clog2(HEIGHT + 1);

    mon_state_e    state_q, state_d;
    logic          vblank_q, vblank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   crc_q, crc_d;
    logic          fb_we_q, fb_we_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]    fb_data_q, fb_data_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   frame_crc_q, frame_crc_d;
    logic          frame_ok_q, frame_ok_d;
    logic [15:0]   frame_num_q, frame_num_d;
    logic          err_overrun_q, err_overrun_d;
    logic          err_underrun_q, err_underrun_d;

    logic [31:0]   crc_upd;
    logic [AW-1:0] addr_cur;
    logic          rise;

    crc32_byte_update u_crc (
        .crc      (crc_q),
        .data     (pixel),
        .crc_next (crc_upd)
    );

    assign addr_cur = AW'(y_q) * AW'(WIDTH) + AW'(x_q);
    assign rise     = vblank & ~vblank_q;

    always_comb begin
        state_d        = state_q;
        vblank_d       = vblank;
        cnt_d          = cnt_q;
        x_d            = x_q;
        y_d            = y_q;
        crc_d          = crc_q;
        fb_we_d        = 1'b0;
        fb_addr_d      = fb_addr_q;
        fb_data_d      = fb_data_q;
        frame_done_d   = 1'b0;
        frame_crc_d    = frame_crc_q;
        frame_ok_d     = frame_ok_q;
        frame_num_d    = frame_num_q;
        err_overrun_d  = err_overrun_q;
        err_underrun_d = err_underrun_q;

        if (state_q == ST_ACTIVE) begin
            if (pixel_en) begin
                if (cnt_q < CW'(TOTAL)) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_cur;
                    fb_data_d = pixel;
                    crc_d     = crc_upd;
                    cnt_d     = cnt_q + CW'(1);
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else begin
                    err_overrun_d = 1'b1;
                end
            end
            // Close sees the pixel accepted on this same cycle, then restarts clean.
            if (rise) begin
                frame_done_d = 1'b1;
                frame_crc_d  = crc_d ^ CRC_XOROUT;
                frame_ok_d   = (cnt_d == CW'(TOTAL));
                frame_num_d  = frame_num_q + 16'd1;
                if (cnt_d < CW'(TOTAL)) begin
                    err_underrun_d = 1'b1;
                end
                crc_d = CRC_INIT;
                cnt_d = '0;
                x_d   = '0;
                y_d   = '0;
            end
        end else if (rise) begin
            state_d = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SYNC;
            vblank_q       <= 1'b1;
            cnt_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            crc_q          <= CRC_INIT;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= '0;
            fb_data_q      <= '0;
            frame_done_q   <= 1'b0;
            frame_crc_q    <= '0;
            frame_ok_q     <= 1'b0;
            frame_num_q    <= '0;
            err_overrun_q  <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vblank_q       <= vblank_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            crc_q          <= crc_d;
            fb_we_q        <= fb_we_d;
            fb_addr_q      <= fb_addr_d;
            fb_data_q      <= fb_data_d;
            frame_done_q   <= frame_done_d;
            frame_crc_q    <= frame_crc_d;
            frame_ok_q     <= frame_ok_d;
            frame_num_q    <= frame_num_d;
            err_overrun_q  <= err_overrun_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_data      = fb_data_q;
    assign frame_done   = frame_done_q;
    assign frame_crc    = frame_crc_q;
    assign frame_ok     = frame_ok_q;
    assign frame_num    = frame_num_q;
    assign err_overrun  = err_overrun_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_frame_crc_monitor.sv
// tb/tb_frame_crc_monitor.sv - self-checking bench for frame_crc_monitor
module tb_frame_crc_monitor;
    import nes_dbg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  s_pixel, d_pixel;
    logic        s_pixel_en, d_pixel_en, s_vblank, d_vblank;
    logic        s_fb_we, d_fb_we;
    logic [15:0] s_fb_addr, d_fb_addr;
    logic [7:0]  s_fb_data, d_fb_data;
    logic        s_frame_done, d_frame_done;
    logic [31:0] s_frame_crc, d_frame_crc;
    logic        s_frame_ok, d_frame_ok;
    logic [15:0] s_frame_num, d_frame_num;
    logic        s_err_overrun, d_err_overrun, s_err_underrun, d_err_underrun;

    frame_crc_monitor #(.WIDTH(9), .HEIGHT(1), .AW(16)) u_small (
        .clk(clk), .rst(rst), .pixel(s_pixel), .pixel_en(s_pixel_en), .vblank(s_vblank),
        .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_data(s_fb_data), .frame_done(s_frame_done),
        .frame_crc(s_frame_crc), .frame_ok(s_frame_ok), .frame_num(s_frame_num),
        .err_overrun(s_err_overrun), .err_underrun(s_err_underrun)
    );

    frame_crc_monitor u_dflt (
        .clk(clk), .rst(rst), .pixel(d_pixel), .pixel_en(d_pixel_en), .vblank(d_vblank),
        .fb_we(d_fb_we), .fb_addr(d_fb_addr), .fb_data(d_fb_data), .frame_done(d_frame_done),
        .frame_crc(d_frame_crc), .frame_ok(d_frame_ok), .frame_num(d_frame_num),
        .err_overrun(d_err_overrun), .err_underrun(d_err_underrun)
    );

    int checks = 0;
    int errors = 0;
    int s_we_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] bytes[$]);
        logic [31:0] c = CRC_INIT;
        foreach (bytes[i]) begin
            c = c ^ {24'h0, bytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c ^ CRC_XOROUT;
    endfunction

    // Reference model of the 9x1 instance: frame contents kept as a byte list.
    localparam int S_TOTAL = 9;
    bit          m_active;
    logic        m_vb_q;
    logic [7:0]  m_q[$];
    logic        m_we, m_done, m_ok, m_ovr, m_und;
    logic [15:0] m_addr, m_num;
    logic [7:0]  m_data;
    logic [31:0] m_crc;

    task automatic model_step(input logic r, input logic en, input logic [7:0] p, input logic vb);
        logic rise;
        if (r) begin
            m_active = 0; m_vb_q = 1'b1; m_q.delete();
            m_we = 0; m_done = 0; m_ok = 0; m_ovr = 0; m_und = 0;
            m_addr = 0; m_num = 0; m_data = 0; m_crc = 0;
            return;
        end
        rise = vb && !m_vb_q;
        m_we = 0;
        m_done = 0;
        if (m_active) begin
            if (en) begin
                if (m_q.size() < S_TOTAL) begin
                    m_we = 1; m_addr = 16'(m_q.size()); m_data = p; m_q.push_back(p);
                end else begin
                    m_ovr = 1;
                end
            end
            if (rise) begin
                m_done = 1;
                m_crc = crc_ref(m_q);
                m_ok = (m_q.size() == S_TOTAL);
                if (m_q.size() < S_TOTAL) m_und = 1;
                m_num = m_num + 16'd1;
                m_q.delete();
            end
        end else if (rise) begin
            m_active = 1;
        end
        m_vb_q = vb;
    endtask

    task automatic s_cycle(input logic r, input logic en, input logic [7:0] p, input logic vb);
        rst = r; s_pixel_en = en; s_pixel = p; s_vblank = vb;
        @(posedge clk);
        #1;
        model_step(r, en, p, vb);
        if (s_fb_we) s_we_cnt++;
        check("model", {s_fb_we, s_frame_done, s_frame_ok, s_err_overrun, s_err_underrun,
                        s_frame_num, s_frame_crc, (m_we ? {s_fb_addr, s_fb_data} : 24'h0)},
                       {m_we, m_done, m_ok, m_ovr, m_und, m_num, m_crc,
                        (m_we ? {m_addr, m_data} : 24'h0)});
    endtask

    typedef struct {
        logic        r, en, vb;
        logic [7:0]  p;
        logic        e_we, e_done, e_ok;
        logic [15:0] e_addr, e_num;
        logic [31:0] e_crc;
    } vec_t;

    function automatic vec_t mk(input logic r, en, input logic [7:0] p, input logic vb,
                                input logic we, input logic [15:0] addr, input logic done,
                                input logic [31:0] crc, input logic ok, input logic [15:0] num);
        vec_t v;
        v.r = r; v.en = en; v.p = p; v.vb = vb;
        v.e_we = we; v.e_addr = addr; v.e_done = done; v.e_crc = crc; v.e_ok = ok; v.e_num = num;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        logic        vb_r;
        logic [7:0]  fq[$];
        int          d_we_cnt, addr_bad;
        logic [15:0] last_addr;
        logic [7:0]  last_data;

        rst = 1'b1; s_pixel = 0; s_pixel_en = 0; s_vblank = 0;
        d_pixel = 0; d_pixel_en = 0; d_vblank = 0;

        tbl[0] = mk(1, 0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[1] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[2] = mk(0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0);
        tbl[3] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < 9; k++)
            tbl[4 + k] = mk(0, 1, 8'(8'h31 + k), 0, 1, 16'(k), 0, 32'h0, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 1, 0, 0, 1, 32'hCBF43926, 1, 1);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'hCBF43926, 1, 1);

        for (int i = 0; i < 15; i++) begin
            s_cycle(tbl[i].r, tbl[i].en, tbl[i].p, tbl[i].vb);
            check($sformatf("vec%0d", i),
                  {s_fb_we, s_frame_done, s_frame_ok, s_frame_num, s_frame_crc,
                   (tbl[i].e_we ? s_fb_addr : 16'h0)},
                  {tbl[i].e_we, tbl[i].e_done, tbl[i].e_ok, tbl[i].e_num, tbl[i].e_crc,
                   tbl[i].e_addr});
        end

        // Last pixel coincides with the vblank rise.
        for (int k = 0; k < 8; k++) s_cycle(0, 1, 8'(8'h31 + k), 0);
        s_cycle(0, 1, 8'h39, 1);
        check("coincide_crc", {s_frame_done, s_frame_ok, s_frame_num, s_frame_crc},
              {1'b1, 1'b1, 16'd2, 32'hCBF43926});
        s_cycle(0, 1, 8'h55, 1);
        check("coincide_next_addr", {s_fb_we, s_fb_addr, s_fb_data}, {1'b1, 16'd0, 8'h55});

        // Underrun: 8 pixels total in this frame.
        for (int k = 0; k < 7; k++) s_cycle(0, 1, 8'(k), 0);
        s_cycle(0, 0, 8'h00, 1);
        check("underrun", {s_frame_done, s_frame_ok, s_err_underrun, s_frame_num},
              {1'b1, 1'b0, 1'b1, 16'd3});

        // Overrun: 10 pixels, the 10th is dropped.
        s_cycle(0, 0, 8'h00, 0);
        s_we_cnt = 0;
        for (int k = 0; k < 10; k++) s_cycle(0, 1, 8'(8'h31 + k), 0);
        check("overrun_flag", {31'h0, s_err_overrun}, 32'h1);
        s_cycle(0, 0, 8'h00, 1);
        check("overrun_writes", 32'(s_we_cnt), 32'd9);
        check("overrun_close", {s_frame_ok, s_frame_num, s_frame_crc}, {1'b1, 16'd4, 32'hCBF43926});

        // SYNC ignores pixels; first rise is silent; reset mid-frame clears everything.
        s_cycle(1, 0, 8'h00, 0);
        s_we_cnt = 0;
        for (int k = 0; k < 3; k++) s_cycle(0, 1, 8'(8'hA0 + k), 0);
        check("sync_no_we", 32'(s_we_cnt), 32'd0);
        s_cycle(0, 0, 8'h00, 1);
        check("sync_first_rise", {s_frame_done, s_frame_num}, {1'b0, 16'd0});
        s_cycle(0, 0, 8'h00, 0);
        for (int k = 0; k < 4; k++) s_cycle(0, 1, 8'(k), 0);
        s_cycle(1, 1, 8'h77, 0);
        check("midframe_reset", {s_fb_we, s_frame_done, s_frame_ok, s_err_overrun, s_err_underrun,
                                 s_frame_num, s_frame_crc}, 53'h0);
        s_cycle(0, 0, 8'h00, 1);
        s_cycle(0, 0, 8'h00, 0);
        s_cycle(0, 0, 8'h00, 1);
        check("reset_rise_silent", {s_frame_done, s_frame_num}, {1'b0, 16'd0});
        s_cycle(0, 1, 8'h12, 1);
        check("reset_addr0", {s_fb_we, s_fb_addr}, {1'b1, 16'd0});

        // Randomised frames of varying length against the model.
        vb_r = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 11) == 0) vb_r = ~vb_r;
            s_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), vb_r);
        end

        // Full default-size frame on the 256x240 instance.
        s_pixel_en = 0; s_vblank = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d_vblank = 0; @(posedge clk); #1;
        d_vblank = 1; @(posedge clk); #1;
        d_vblank = 0; @(posedge clk); #1;
        d_we_cnt = 0; addr_bad = 0; last_addr = 0; last_data = 0;
        for (int i = 0; i < 61440; i++) begin
            d_pixel = 8'(i % 256);
            d_pixel_en = 1'b1;
            fq.push_back(d_pixel);
            @(posedge clk); #1;
            if (d_fb_we) begin
                d_we_cnt++;
                if (d_fb_addr !== 16'(i) || d_fb_data !== 8'(i % 256)) addr_bad++;
                last_addr = d_fb_addr;
                last_data = d_fb_data;
            end
        end
        d_pixel_en = 1'b0;
        d_vblank = 1'b1;
        @(posedge clk); #1;
        if (d_fb_we) d_we_cnt++;
        check("full_we_count", 32'(d_we_cnt), 32'd61440);
        check("full_addr_seq", 32'(addr_bad), 32'd0);
        check("full_last_write", {last_addr, last_data}, {16'hEFFF, 8'hFF});
        check("full_close", {d_frame_done, d_frame_ok, d_err_overrun, d_err_underrun, d_frame_num},
              {1'b1, 1'b1, 1'b0, 1'b0, 16'd1});
        check("full_crc", d_frame_crc, crc_ref(fq));
        d_vblank = 1'b0;
        @(posedge clk); #1;
        check("full_done_pulse", {d_frame_done, d_frame_crc}, {1'b0, crc_ref(fq)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
